// File: rtl/beta_read_return_mux_if.sv
// Read-return bus between the Beta memory port, the read sources and the return mux.
// The master side issues reads and models the sources. The slave side is the mux.
interface beta_read_return_mux_if #(
   parameter int NSRC  = 4,
   parameter int DW    = 32,
   parameter int SELW  = 3,
   parameter int DEPTH = 4
);
   logic                        req;
   logic [SELW-1:0]             req_sel;
   logic                        req_ready;
   logic [NSRC*DW-1:0]          src_dout;
   logic [NSRC-1:0]             src_valid;
   logic [NSRC-1:0]             src_ack;
   logic [DW-1:0]               beta_mdin;
   logic                        mdin_valid;
   logic                        mdin_err;
   logic [$clog2(DEPTH):0]      pending;

   modport master (
      output req, req_sel, src_dout, src_valid,
      input  req_ready, src_ack, beta_mdin, mdin_valid, mdin_err, pending
   );

   modport slave (
      input  req, req_sel, src_dout, src_valid,
      output req_ready, src_ack, beta_mdin, mdin_valid, mdin_err, pending
   );
endinterface

// File: rtl/beta_read_return_mux.sv
// In-order read-return mux: tracks the source of each issued read and returns the
// source's word, or ERR_DATA on a bad select or watchdog expiry, as a registered word.
module beta_read_return_mux #(
   parameter int            NSRC     = 4,
   parameter int            DW       = 32,
   parameter int            SELW     = 3,
   parameter int            DEPTH    = 4,
   parameter int            TIMEOUT  = 64,
   parameter logic [DW-1:0] ERR_DATA = {DW{1'b0}}
)(
   input logic                   clk,
   input logic                   reset,
   beta_read_return_mux_if.slave bus_io
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [SELW-1:0] fifo_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [DW-1:0]   mdin_q, mdin_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic            enq_s;
   logic            head_v_s;
   logic [SELW-1:0] head_sel_s;
   logic            bad_s;
   logic            hit_s;
   logic [DW-1:0]   hit_data_s;
   logic [NSRC-1:0] ack_s;
   logic            tmo_s;
   logic            retire_s;
   logic            rerr_s;

   assign enq_s      = bus_io.req && (count_q != CW'(DEPTH));
   assign head_v_s   = (count_q != {CW{1'b0}});
   assign head_sel_s = fifo_q[rd_ptr_q];
   // NSRC may equal 2**SELW, so compare with one extra bit.
   assign bad_s      = ({1'b0, head_sel_s} >= (SELW+1)'(NSRC));
   assign tmo_s      = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

   // Look up the head's source; only the head source can be acknowledged.
   always_comb begin
      hit_s      = 1'b0;
      hit_data_s = {DW{1'b0}};
      ack_s      = {NSRC{1'b0}};
      for (int i = 0; i < NSRC; i++) begin
         if (head_v_s && (head_sel_s == SELW'(i)) && bus_io.src_valid[i]) begin
            hit_s      = 1'b1;
            hit_data_s = bus_io.src_dout[i*DW +: DW];
            ack_s[i]   = 1'b1;
         end else begin
            ack_s[i]   = 1'b0;
         end
      end
   end

   assign retire_s = head_v_s && (bad_s || hit_s || tmo_s);
   assign rerr_s   = head_v_s && (bad_s || (!hit_s && tmo_s));

   // Next-state for pointers, occupancy, watchdog and the return register.
   always_comb begin
      wr_ptr_d = enq_s    ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = retire_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({enq_s, retire_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (!head_v_s || retire_s) begin
         timer_d = {TW{1'b0}};
      end else begin
         timer_d = timer_q + TW'(1);
      end
      if (retire_s) begin
         mdin_d = rerr_s ? ERR_DATA : hit_data_s;
      end else begin
         mdin_d = mdin_q;
      end
      valid_d = retire_s;
      err_d   = retire_s && rerr_s;
   end

   // State registers with synchronous flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= {SELW{1'b0}};
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         timer_q  <= {TW{1'b0}};
         mdin_q   <= {DW{1'b0}};
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (enq_s) begin
            fifo_q[wr_ptr_q] <= bus_io.req_sel;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         mdin_q   <= mdin_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign bus_io.req_ready  = (count_q != CW'(DEPTH));
   assign bus_io.pending    = count_q;
   assign bus_io.src_ack    = ack_s;
   assign bus_io.beta_mdin  = mdin_q;
   assign bus_io.mdin_valid = valid_q;
   assign bus_io.mdin_err   = err_q;
endmodule

// File: tb/tb_beta_read_return_mux.sv
// Bench for beta_read_return_mux: queue-based source models plus an in-order scoreboard
// that holds the expected word, error flag and arrival cycle of each return.
module tb_beta_read_return_mux;
   localparam int NSRC = 4;
   localparam int DW = 32;
   localparam int SELW = 3;
   localparam int DEPTH = 4;
   localparam int TIMEOUT = 64;
   localparam logic [DW-1:0] ERRW = 32'hBAD0_BAD0;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   beta_read_return_mux_if #(.NSRC(NSRC), .DW(DW), .SELW(SELW), .DEPTH(DEPTH)) bus ();

   beta_read_return_mux #(
      .NSRC(NSRC), .DW(DW), .SELW(SELW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus_io(bus)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      int            cyc;
   } exp_t;

   typedef struct {
      logic [SELW-1:0] sel;
      logic [DW-1:0]   data;
      logic [DW-1:0]   exp_data;
      logic            exp_err;
   } vec_t;

   exp_t            sb[$];
   logic [DW-1:0]   srcq[NSRC][$];
   logic [NSRC-1:0] src_en = '0;
   logic [NSRC-1:0] ack_seen = '0;
   int              ack_cnt = 0;
   int              last_ack_cyc = -1;
   logic [NSRC-1:0] last_ack_bits = '0;
   int              maxp = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void refresh();
      for (int i = 0; i < NSRC; i++) begin
         bus.src_valid[i] = src_en[i] && (srcq[i].size() > 0);
         bus.src_dout[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0] : {DW{1'b0}};
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [SELW-1:0] sel, input logic [DW-1:0] d, input logic e, input int c);
      exp_t x;
      x.data = d; x.err = e; x.cyc = c;
      sb.push_back(x);
      bus.req = 1'b1;
      bus.req_sel = sel;
      tick();
      bus.req = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check("drain", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   // Monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mdin_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("mdin_data", 64'(bus.beta_mdin), 64'(e.data));
               check("mdin_err", 64'(bus.mdin_err), 64'(e.err));
               if (e.cyc >= 0) check("mdin_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (bus.src_ack !== '0) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            last_ack_bits = bus.src_ack;
            if (!$onehot(bus.src_ack)) check("ack_onehot", 64'(bus.src_ack), 64'd0);
         end
         if (int'(bus.pending) > maxp) maxp = int'(bus.pending);
      end
      ack_seen = bus.src_ack;
   end

   // Source models: drop the front word once it has been acknowledged.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NSRC; i++) begin
         if (ack_seen[i] === 1'b1 && srcq[i].size() > 0) void'(srcq[i].pop_front());
      end
      ack_seen = '0;
      refresh();
   end

   initial begin
      vec_t vecs[7];
      int c, a;
      vecs[0] = '{3'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{3'd1, 32'h12345678, 32'h12345678, 1'b0};
      vecs[2] = '{3'd2, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
      vecs[3] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
      vecs[4] = '{3'd5, 32'h0,        ERRW,         1'b1};
      vecs[5] = '{3'd4, 32'h0,        ERRW,         1'b1};
      vecs[6] = '{3'd7, 32'h0,        ERRW,         1'b1};

      reset = 1'b1;
      bus.req = 1'b0;
      bus.req_sel = '0;
      refresh();
      repeat (3) tick();
      reset = 1'b0;
      check("rst_pending", 64'(bus.pending), 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd1);
      check("rst_ack", 64'(bus.src_ack), 64'd0);
      check("rst_mdin", 64'(bus.beta_mdin), 64'd0);
      check("rst_valid", 64'(bus.mdin_valid), 64'd0);
      check("rst_err", 64'(bus.mdin_err), 64'd0);

      // Single reads: good sources and bad selects, fixed two-cycle latency.
      src_en = '1;
      for (int k = 0; k < 7; k++) begin
         if (int'(vecs[k].sel) < NSRC) srcq[vecs[k].sel].push_back(vecs[k].data);
         refresh();
         a = ack_cnt;
         c = cyc;
         issue(vecs[k].sel, vecs[k].exp_data, vecs[k].exp_err, c + 2);
         wait_drain(20);
         if (!vecs[k].exp_err) begin
            check("ack_cycle", 64'(last_ack_cyc), 64'(c + 1));
            check("ack_bits", 64'(last_ack_bits), 64'(1 << vecs[k].sel));
         end else begin
            check("bad_no_ack", 64'(ack_cnt - a), 64'd0);
         end
         tick();
      end

      // Back-to-back reads, one return per cycle.
      for (int i = 0; i < NSRC; i++) srcq[i].push_back(32'hB0B0_0000 + 32'(i));
      refresh();
      maxp = 0;
      c = cyc;
      for (int i = 0; i < NSRC; i++) issue(SELW'(i), 32'hB0B0_0000 + 32'(i), 1'b0, c + 2 + i);
      wait_drain(20);
      check("b2b_peak_ok", 64'(maxp >= 1 && maxp <= DEPTH), 64'd1);
      tick();

      // Fill to DEPTH with idle sources, extra request dropped, then release.
      src_en = '0;
      for (int i = 0; i < NSRC; i++) srcq[i].push_back(32'hC0DE_0000 + 32'(i));
      refresh();
      c = cyc;
      for (int i = 0; i < NSRC; i++) begin
         check("fill_ready", 64'(bus.req_ready), 64'd1);
         issue(SELW'(i), 32'hC0DE_0000 + 32'(i), 1'b0, c + 6 + i);
      end
      check("full_ready", 64'(bus.req_ready), 64'd0);
      check("full_pending", 64'(bus.pending), 64'd4);
      bus.req = 1'b1;
      bus.req_sel = 3'd0;
      tick();
      bus.req = 1'b0;
      check("full_ignored", 64'(bus.pending), 64'd4);
      src_en = '1;
      refresh();
      wait_drain(20);
      check("full_drained", 64'(bus.pending), 64'd0);
      tick();

      // Watchdog on a source that never answers.
      c = cyc;
      issue(3'd1, ERRW, 1'b1, c + 65);
      check("tmo_pending", 64'(bus.pending), 64'd1);
      wait_drain(100);
      check("tmo_pending_after", 64'(bus.pending), 64'd0);
      tick();

      // Reset with reads in flight drops them silently.
      src_en = '0;
      srcq[0].push_back(32'h600D_F00D);
      refresh();
      for (int i = 0; i < 3; i++) begin
         bus.req = 1'b1;
         bus.req_sel = 3'd0;
         tick();
      end
      bus.req = 1'b0;
      check("inflight_pending", 64'(bus.pending), 64'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_pending", 64'(bus.pending), 64'd0);
      check("mid_rst_ready", 64'(bus.req_ready), 64'd1);
      a = ack_cnt;
      src_en = '1;
      refresh();
      repeat (10) tick();
      check("mid_rst_no_ack", 64'(ack_cnt - a), 64'd0);
      check("mid_rst_word_kept", 64'(srcq[0].size()), 64'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end
endmodule
